instr_fetch_unit: RTL and testbench

- Instruction fetch front end. Owns the program counter and drives the address of the 64x16 combinational instruction ROM.
- Registers the returned word into an instruction register for the decode stage.
- Handles start, stall, branch/jump redirect, PC wrap-around and optional halt-on-zero.
- Sits between the instruction ROM and the decoder/control unit of the 16-bit RISC processor.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/instr_fetch_unit_pc_reg.sv | 38 +++
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    // Fetch sequencer states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } ifetch_state_t;

    localparam int IFETCH_ADDR_W = 6;
    localparam int IFETCH_INST_W = 16;

    // Instruction word that stops fetching when halt-on-zero is built in
    localparam logic [IFETCH_INST_W-1:0] HALT_WORD = 16'h0000;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with load / increment / hold. The increment
//               wraps modulo 2^ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
    parameter int                ADDR_W   = 6,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc;

    // Load has priority over increment; neither means hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_val;
        end else if (i_inc) begin
            r_pc <= r_pc + c_one;
        end
    end

    assign o_pc = r_pc;

endmodule : pc_reg
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch front end: owns the PC, addresses the combinational
//               instruction ROM and registers the returned word for decode.
//               Optional macro IFETCH_HALT_ON_ZERO_EN makes a fetched 16'h0000
//               park the unit in HALT instead of issuing it.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = IFETCH_ADDR_W,
    parameter int                INST_W   = IFETCH_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] address,
    input  logic [INST_W-1:0] mem_data,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    output logic              halted
);

    ifetch_state_t     r_state;
    ifetch_state_t     w_next_state;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_valid;
    logic [ADDR_W-1:0] w_pc;
    logic              w_pc_load;
    logic [ADDR_W-1:0] w_pc_load_val;
    logic              w_pc_inc;
    logic              w_issue;
    logic              w_flush;
    logic              w_drop_valid;
    logic              w_is_halt_word;

`ifdef IFETCH_HALT_ON_ZERO_EN
    assign w_is_halt_word = (mem_data == INST_W'(HALT_WORD));
    assign halted         = (r_state == HALT);
`else
    assign w_is_halt_word = 1'b0;
    assign halted         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and PC / instruction-register control
    always_comb begin
        w_next_state  = r_state;
        w_pc_load     = 1'b0;
        w_pc_load_val = RESET_PC;
        w_pc_inc      = 1'b0;
        w_issue       = 1'b0;
        w_flush       = 1'b0;
        w_drop_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                    w_pc_load    = 1'b1;
                end
            end
            RUN: begin
                // Redirect beats stall; a redirect leaves one flush bubble
                if (redirect) begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = redirect_pc;
                    w_flush       = 1'b1;
                end else if (stall) begin
                    w_pc_load     = 1'b0;
                end else if (w_is_halt_word) begin
                    w_next_state  = HALT;
                    w_drop_valid  = 1'b1;
                end else begin
                    w_issue       = 1'b1;
                    w_pc_inc      = 1'b1;
                end
            end
            HALT: begin
                if (start) begin
                    w_next_state = RUN;
                    w_pc_load    = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Instruction register, its fetch address and valid flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else if (w_flush) begin
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
        end else if (w_issue) begin
            r_inst       <= mem_data;
            r_inst_pc    <= w_pc;
            r_inst_valid <= 1'b1;
        end else if (w_drop_valid) begin
            r_inst_valid <= 1'b0;
        end
    end

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_pc_load),
        .i_load_val (w_pc_load_val),
        .i_inc      (w_pc_inc),
        .o_pc       (w_pc)
    );

    assign address    = w_pc;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_valid = r_inst_valid;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with a
//               behavioural 64x16 ROM. Honours IFETCH_HALT_ON_ZERO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic [5:0]  address;
    logic [15:0] mem_data;
    logic [15:0] inst;
    logic [5:0]  inst_pc;
    logic        inst_valid;
    logic        halted;

    logic [15:0] rom [0:63];
    int          n_cmp;
    int          n_err;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .address     (address),
        .mem_data    (mem_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .halted      (halted)
    );

    // Combinational ROM
    assign mem_data = rom[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag, input logic [15:0] e_inst,
                               input logic [5:0] e_ipc, input logic e_valid,
                               input logic [5:0] e_addr);
        check({tag, ".inst"},  {16'h0, inst},     {16'h0, e_inst});
        check({tag, ".ipc"},   {26'h0, inst_pc},  {26'h0, e_ipc});
        check({tag, ".valid"}, {31'h0, inst_valid}, {31'h0, e_valid});
        check({tag, ".addr"},  {26'h0, address},  {26'h0, e_addr});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) rom[i] = 16'hA000 + 16'(i);
        rom[0]  = 16'hB040;
        rom[1]  = 16'hB210;
        rom[2]  = 16'hC250;
        rom[4]  = 16'hB40F;
        rom[8]  = 16'h4F59;
        rom[25] = 16'h0000;

        rst = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 6'd0;
        #3;
        check_fetch("reset", 16'h0000, 6'd0, 1'b0, 6'd0);
        check("reset.halted", {31'h0, halted}, 32'h0);
        #4 rst = 1'b0;
        step(); step();
        check_fetch("idle", 16'h0000, 6'd0, 1'b0, 6'd0);

        // Start and free-run through words 0..3
        start = 1'b1;
        step();
        start = 1'b0;
        check_fetch("start", 16'h0000, 6'd0, 1'b0, 6'd0);
        step(); check_fetch("f0", 16'hB040, 6'd0, 1'b1, 6'd1);
        step(); check_fetch("f1", 16'hB210, 6'd1, 1'b1, 6'd2);
        step(); check_fetch("f2", 16'hC250, 6'd2, 1'b1, 6'd3);
        step(); check_fetch("f3", 16'hA003, 6'd3, 1'b1, 6'd4);

        // Stall three cycles at pc=4
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); check_fetch("stall", 16'hA003, 6'd3, 1'b1, 6'd4);
        end
        stall = 1'b0;
        step(); check_fetch("resume", 16'hB40F, 6'd4, 1'b1, 6'd5);

        // Redirect together with stall: redirect wins
        redirect = 1'b1; redirect_pc = 6'd8; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        check_fetch("redir", 16'h0000, 6'd4, 1'b0, 6'd8);
        step(); check_fetch("redir_tgt", 16'h4F59, 6'd8, 1'b1, 6'd9);

        // Start while running is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        check_fetch("start_in_run", 16'hA009, 6'd9, 1'b1, 6'd10);

        // Wrap-around 63 -> 0
        redirect = 1'b1; redirect_pc = 6'd63;
        step();
        redirect = 1'b0;
        check_fetch("redir63", 16'h0000, 6'd9, 1'b0, 6'd63);
        step(); check_fetch("f63", 16'hA03F, 6'd63, 1'b1, 6'd0);
        step(); check_fetch("wrap0", 16'hB040, 6'd0, 1'b1, 6'd1);

        // Zero word at address 25
        redirect = 1'b1; redirect_pc = 6'd24;
        step();
        redirect = 1'b0;
        check_fetch("redir24", 16'h0000, 6'd0, 1'b0, 6'd24);
        step(); check_fetch("f24", 16'hA018, 6'd24, 1'b1, 6'd25);
        step();
`ifdef IFETCH_HALT_ON_ZERO_EN
        check_fetch("halt", 16'hA018, 6'd24, 1'b0, 6'd25);
        check("halt.halted", {31'h0, halted}, 32'h1);
        redirect = 1'b1; redirect_pc = 6'd5; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        check_fetch("halt_hold", 16'hA018, 6'd24, 1'b0, 6'd25);
        check("halt_hold.halted", {31'h0, halted}, 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_fetch("restart", 16'hA018, 6'd24, 1'b0, 6'd0);
        check("restart.halted", {31'h0, halted}, 32'h0);
        step(); check_fetch("restart_f0", 16'hB040, 6'd0, 1'b1, 6'd1);
`else
        check_fetch("zero_issue", 16'h0000, 6'd25, 1'b1, 6'd26);
        check("zero_issue.halted", {31'h0, halted}, 32'h0);
        step(); check_fetch("f26", 16'hA01A, 6'd26, 1'b1, 6'd27);
`endif

        // Asynchronous reset mid-run at pc=13
        redirect = 1'b1; redirect_pc = 6'd12;
        step();
        redirect = 1'b0;
        step(); check_fetch("f12", 16'hA00C, 6'd12, 1'b1, 6'd13);
        #2 rst = 1'b1;
        #1;
        check_fetch("async_rst", 16'h0000, 6'd0, 1'b0, 6'd0);
        check("async_rst.halted", {31'h0, halted}, 32'h0);
        #3 rst = 1'b0;
        step(); step(); step();
        check_fetch("post_rst_idle", 16'h0000, 6'd0, 1'b0, 6'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step(); check_fetch("post_rst_f0", 16'hB040, 6'd0, 1'b1, 6'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_instr_fetch_unit
`default_nettype wire
